// File: rtl/intbus_rd_master.sv
// Host-to-intbus master: issues one read or write per request, waits for rvalid or times out.
// Optional timeout statistic counter enabled by defining INTBUS_RD_MASTER_TIMEOUT_STAT_EN.
module intbus_rd_master #(
  parameter int                    ADDR_WIDTH   = 30,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    TIMEOUT      = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_timeout_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_rd_o,
  output logic                  bus_wr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_rvalid_i,
  output logic [15:0]           timeout_cnt_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_rd_q, bus_rd_d;
  logic                  bus_wr_q, bus_wr_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_timeout_q, resp_timeout_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_rd_q       <= 1'b0;
      bus_wr_q       <= 1'b0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_rd_q       <= bus_rd_d;
      bus_wr_q       <= bus_wr_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  // Strobes default low so each is a single-cycle pulse; rvalid is only looked at in RD_WAIT.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_rd_d       = 1'b0;
    bus_wr_d       = 1'b0;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          bus_addr_d = req_addr_i;
          if (req_wr_i) begin
            bus_wdata_d    = req_wdata_i;
            bus_wr_d       = 1'b1;
            resp_data_d    = '0;
            resp_timeout_d = 1'b0;
            state_d        = RESP;
          end else begin
            bus_rd_d = 1'b1;
            timer_d  = '0;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus_rvalid_i) begin
          resp_data_d    = bus_rdata_i;
          resp_timeout_d = 1'b0;
          state_d        = RESP;
        end else if (timer_q == TIMER_TERM) begin
          resp_data_d    = TIMEOUT_DATA;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o    = (state_q == IDLE) & ~rst_i;
  assign resp_valid_o   = (state_q == RESP);
  assign resp_data_o    = resp_data_q;
  assign resp_timeout_o = resp_timeout_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign bus_rd_o       = bus_rd_q;
  assign bus_wr_o       = bus_wr_q;

`ifdef INTBUS_RD_MASTER_TIMEOUT_STAT_EN
  logic [15:0] stat_q;
  logic        timeout_evt;

  assign timeout_evt = (state_q == RD_WAIT) & ~bus_rvalid_i & (timer_q == TIMER_TERM);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (timeout_evt && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign timeout_cnt_o = stat_q;
`else
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_intbus_rd_master.sv
// Scoreboard bench for intbus_rd_master: expected responses queued at request time, popped at response.
module tb_intbus_rd_master;

  localparam int          AW      = 30;
  localparam int          DW      = 32;
  localparam int          TO      = 64;
  localparam logic [31:0] TO_DATA = 32'hDEADBEEF;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_wr_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [DW-1:0] resp_data_o;
  logic          resp_timeout_o;
  logic [AW-1:0] bus_addr_o;
  logic          bus_rd_o;
  logic          bus_wr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i = '0;
  logic          bus_rvalid_i = 1'b0;
  logic [15:0]   timeout_cnt_o;

  intbus_rd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .TIMEOUT_DATA(TO_DATA)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_timeout_o(resp_timeout_o),
    .bus_addr_o(bus_addr_o), .bus_rd_o(bus_rd_o), .bus_wr_o(bus_wr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_rvalid_i(bus_rvalid_i),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic          timeout;
  } exp_t;

  exp_t          sb[$];
  int            compared = 0;
  int            mismatched = 0;
  int            expTimeouts = 0;
  logic [DW-1:0] lastData = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] expStat();
`ifdef INTBUS_RD_MASTER_TIMEOUT_STAT_EN
    return expTimeouts[15:0];
`else
    return 16'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready_o, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid_o, 0);
    checkOutput({tag, "_resp_data"}, resp_data_o, 0);
    checkOutput({tag, "_resp_timeout"}, resp_timeout_o, 0);
    checkOutput({tag, "_bus_addr"}, bus_addr_o, 0);
    checkOutput({tag, "_bus_rd"}, bus_rd_o, 0);
    checkOutput({tag, "_bus_wr"}, bus_wr_o, 0);
    checkOutput({tag, "_bus_wdata"}, bus_wdata_o, 0);
    checkOutput({tag, "_timeout_cnt"}, timeout_cnt_o, 0);
  endtask

  // Pops the expected response, optionally stalls resp_ready with a competing request, then hands off.
  task automatic collectResponse(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput("resp_valid", resp_valid_o, 1);
    checkOutput("resp_data", resp_data_o, e.data);
    checkOutput("resp_timeout", resp_timeout_o, e.timeout);
    checkOutput("timeout_cnt", timeout_cnt_o, expStat());
    lastData = e.data;
    if (hold > 0) begin
      req_valid_i = 1'b1;
      req_wr_i    = 1'b0;
      req_addr_i  = 30'h3FF;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("hold_valid", resp_valid_o, 1);
      checkOutput("hold_data", resp_data_o, e.data);
      checkOutput("hold_ready", req_ready_o, 0);
      checkOutput("hold_no_rd", bus_rd_o, 0);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    checkOutput("resp_drop", resp_valid_o, 0);
    checkOutput("ready_back", req_ready_o, 1);
  endtask

  // lat = cycles after the rd cycle at which the slave raises rvalid; lat >= TO means no response.
  task automatic doRead(input logic [AW-1:0] addr, input int lat, input logic [DW-1:0] data,
                        input int hold, input int abortAt);
    exp_t e;
    int   m;
    bit   seen;
    checkOutput("idle_ready", req_ready_o, 1);
    e.timeout = (lat > TO - 1);
    e.data    = e.timeout ? TO_DATA : data;
    sb.push_back(e);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b0;
    req_addr_i  = addr;
    req_wdata_i = $urandom;
    tick();
    req_valid_i = 1'b0;
    checkOutput("rd_strobe", bus_rd_o, 1);
    checkOutput("rd_addr", bus_addr_o, addr);
    seen = 1'b0;
    m    = 0;
    for (int k = 0; k < TO + 10 && !seen; k++) begin
      bus_rvalid_i = (k == lat);
      bus_rdata_i  = (k == lat) ? data : '0;
      if (k == abortAt) begin
        #2 rst_i = 1'b1;
        #1;
        checkResetValues("abort");
        void'(sb.pop_back());
        expTimeouts = 0;
        tick();
        tick();
        rst_i = 1'b0;
        for (int q = 0; q < 3; q++) begin
          tick();
          checkOutput("abort_no_resp", resp_valid_o, 0);
        end
        checkOutput("abort_ready", req_ready_o, 1);
        return;
      end
      tick();
      if (k == 0) checkOutput("rd_once", bus_rd_o, 0);
      if (resp_valid_o) begin
        seen = 1'b1;
        m    = k + 1;
      end
    end
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    if (!seen) begin
      checkOutput("resp_wait", 0, 1);
      void'(sb.pop_back());
    end else begin
      if (e.timeout) expTimeouts++;
      checkOutput("resp_latency", m, e.timeout ? TO : lat + 1);
      collectResponse(hold);
    end
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t e;
    checkOutput("idle_ready", req_ready_o, 1);
    e.data    = '0;
    e.timeout = 1'b0;
    sb.push_back(e);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    tick();
    req_valid_i = 1'b0;
    req_wr_i    = 1'b0;
    checkOutput("wr_strobe", bus_wr_o, 1);
    checkOutput("wr_addr", bus_addr_o, addr);
    checkOutput("wr_data", bus_wdata_o, wdata);
    checkOutput("wr_no_rd", bus_rd_o, 0);
    collectResponse(0);
    checkOutput("wr_once", bus_wr_o, 0);
    checkOutput("wr_hold_addr", bus_addr_o, addr);
    checkOutput("wr_hold_data", bus_wdata_o, wdata);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 3; i++) tick();
    checkResetValues("reset");
    rst_i = 1'b0;
    tick();
    checkOutput("post_reset_ready", req_ready_o, 1);

    doRead(30'h0000_0100, 25, 32'h12345678, 0, -1);
    doRead(30'h0000_0104, 0, 32'hCAFEF00D, 0, -1);
    doRead(30'h3ABC_0000, 1000, 32'h0, 0, -1);
    doWrite(30'h10, 32'hA5A5A5A5);
    doRead(30'h0000_0200, 5, 32'h0BADC0DE, 10, -1);
    doRead(30'h0000_0204, TO - 1, 32'h600DF00D, 0, -1);

    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h55AA55AA;
    tick();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    checkOutput("stray_data", resp_data_o, lastData);
    checkOutput("stray_valid", resp_valid_o, 0);
    checkOutput("stray_ready", req_ready_o, 1);
    tick();
    checkOutput("stray_data_later", resp_data_o, lastData);

    doRead(30'h0000_0300, 1000, 32'h0, 0, 10);
    doRead(30'h0000_0304, 3, 32'h13579BDF, 0, -1);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1)
        doWrite(AW'($urandom), $urandom);
      else
        doRead(AW'($urandom), int'($urandom_range(0, 30)), $urandom, int'($urandom_range(0, 3)), -1);
    end
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/intbus_rd_master.md
Name: intbus_rd_master

Overview:
- Bus-master front end for the internal register bus (intbus).
- Accepts single read/write requests from a host-side port (UART/SPI/CPU bridge), then drives one bus transaction to all slaves.
- Reads wait for a slave's rvalid, with a programmable timeout. Writes complete in one bus cycle.
- Upstream feeder of every intbus slave, including fixed-latency test slaves (rvalid up to 25 cycles after rd).

Parameters:
- ADDR_WIDTH, 30, width of bus and request address.
- DATA_WIDTH, 32, width of read/write data.
- TIMEOUT, 64, cycles to wait for rvalid after the rd pulse before declaring a timeout. Must be > 1. Must exceed the slowest slave latency.
- TIMEOUT_DATA, 32'hDEADBEEF, value returned on resp_data when a read times out.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts response.
- resp_data  out  DATA_WIDTH  read data (0 for writes).
- resp_timeout  out  1  response is a read timeout.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_rd  out  1  one-cycle read strobe.
- bus_wr  out  1  one-cycle write strobe.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_rdata  in  DATA_WIDTH  OR-combined slave read data (0 from non-responding slaves).
- bus_rvalid  in  1  OR-combined slave read valid.
- timeout_cnt  out  16  timeout statistic (see Optional Feature).

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. resp_valid=0, resp_data=0, resp_timeout=0, bus_addr=0, bus_rd=0, bus_wr=0, bus_wdata=0, timeout_cnt=0. FSM state = IDLE, timer = 0.
- FSM states: IDLE, RD_WAIT, RESP.
- req_ready = 1 only in IDLE. A handshake occurs when req_valid & req_ready.
- IDLE, read accepted at edge N:
  - bus_addr latched; bus_rd=1 for exactly cycle N+1; timer cleared to 0; go to RD_WAIT.
- IDLE, write accepted at edge N:
  - bus_addr and bus_wdata latched; bus_wr=1 for cycle N+1; go to RESP with resp_data=0, resp_timeout=0.
  - resp_valid rises at N+1.
- RD_WAIT:
  - Timer increments each cycle.
  - bus_rvalid=1: capture bus_rdata into resp_data, resp_timeout=0, go to RESP. resp_valid is asserted the cycle after rvalid.
  - rvalid sampled in the same cycle as bus_rd counts as valid (zero-latency slave).
  - Timer reaches TIMEOUT-1 with no rvalid: resp_data=TIMEOUT_DATA, resp_timeout=1, go to RESP.
  - rvalid and timeout in the same cycle: rvalid wins, no timeout.
- RESP:
  - resp_valid and resp_data held stable until resp_ready=1; then return to IDLE.
  - req_ready returns next cycle; back-to-back issue gap is 1 cycle.
- bus_addr and bus_wdata are held after the strobe until the next request.
- rvalid outside RD_WAIT is ignored (late or stray response); resp_data is unaffected.
- Timer width: clog2(TIMEOUT)+1 bits. It never wraps; it stops at the terminal count.
- Reset mid-transaction: immediate return to reset values. Strobes drop asynchronously. No response is issued for the aborted request.

Optional Feature:
- Macro: INTBUS_RD_MASTER_TIMEOUT_STAT_EN.
- Defined: timeout_cnt increments by 1 on each timeout transition into RESP. It saturates at 16'hFFFF and is cleared only by rst.
- Not defined: timeout_cnt is tied to 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Read to a slave with 25-cycle latency returning 32'h12345678: bus_rd pulses once, resp_valid arrives 26 cycles after bus_rd, resp_data=32'h12345678, resp_timeout=0.
- Read to an unmapped address, no rvalid: resp_valid after TIMEOUT=64 cycles, resp_data=32'hDEADBEEF, resp_timeout=1. With the macro defined, timeout_cnt goes 0->1.
- Write addr=30'h10, wdata=32'hA5A5A5A5: bus_wr high exactly 1 cycle with those values, resp_valid next cycle, resp_data=0.
- resp_ready held low 10 cycles after a read response: resp_valid and resp_data stable throughout, req_ready=0, a new req_valid is not accepted. Release: IDLE, next read accepted.
- rvalid arriving exactly on the timeout cycle: response is data, resp_timeout=0, timeout_cnt unchanged. A stray rvalid in IDLE leaves outputs unchanged.
- rst asserted during RD_WAIT at cycle 10: all outputs reset asynchronously, no resp_valid. After release, a fresh read completes normally.
